// File: rtl/pixel_streamer.sv
// Streams a square image out of a synchronous-read memory in row-major order,
// with optional idle gaps between rows, downstream pause, and a frame-done pulse.
module pixel_streamer #(
  parameter int input_width = 8,
  parameter int im_dim      = 28,
  parameter int row_gap     = 0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic                               pause_i,
  output logic                               mem_rd_o,
  output logic [$clog2(im_dim*im_dim)-1:0]   mem_addr_o,
  input  logic [input_width-1:0]             mem_data_i,
  output logic [input_width-1:0]             pixel_o,
  output logic                               pix_data_valid,
  output logic                               row_last_o,
  output logic                               frame_last_o,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int NPIX = im_dim * im_dim;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = (im_dim > 1) ? $clog2(im_dim) : 1;
  localparam int GW   = $clog2(row_gap + 2);

  typedef enum logic [1:0] {IDLE, STREAM, GAP, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, row_q;
  logic [AW-1:0]   addr_q;
  logic [GW-1:0]   gap_q;
  logic            col_end, last_row;
  logic            rd_d1, rl_d1, fl_d1;

  assign col_end    = (col_q == CW'(im_dim - 1));
  assign last_row   = (row_q == CW'(im_dim - 1));
  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q != IDLE);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    mem_rd_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = STREAM;
      end
      STREAM: begin
        if (!pause_i) begin
          mem_rd_o = 1'b1;
          if (col_end) begin
            if (last_row)         state_d = DRAIN;
            else if (row_gap > 0) state_d = GAP;
          end
        end
      end
      GAP: begin
        if (int'(gap_q) >= row_gap - 1) state_d = STREAM;
      end
      DRAIN: begin
        // Leave as the last pixel emerges so IDLE coincides with done_o.
        if (pix_data_valid && frame_last_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= (state_q == GAP) ? gap_q + GW'(1) : '0;
      if (state_q == IDLE && start_i) begin
        col_q  <= '0;
        row_q  <= '0;
        addr_q <= '0;
      end else if (mem_rd_o) begin
        if (col_end) begin
          col_q  <= '0;
          row_q  <= last_row ? '0 : row_q + CW'(1);
          addr_q <= last_row ? '0 : addr_q + AW'(1);
        end else begin
          col_q  <= col_q + CW'(1);
          addr_q <= addr_q + AW'(1);
        end
      end
    end
  end

  // Two-stage side-band pipeline: stage 1 waits for memory data, stage 2 registers it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_d1          <= 1'b0;
      rl_d1          <= 1'b0;
      fl_d1          <= 1'b0;
      pix_data_valid <= 1'b0;
      row_last_o     <= 1'b0;
      frame_last_o   <= 1'b0;
      pixel_o        <= '0;
      done_o         <= 1'b0;
    end else begin
      rd_d1          <= mem_rd_o;
      rl_d1          <= mem_rd_o & col_end;
      fl_d1          <= mem_rd_o & col_end & last_row;
      pix_data_valid <= rd_d1;
      row_last_o     <= rl_d1;
      frame_last_o   <= fl_d1;
      if (rd_d1) pixel_o <= mem_data_i;
      done_o         <= pix_data_valid & frame_last_o;
    end
  end

endmodule
